// File: rtl/kulisch_product_accumulator.sv
// Kulisch product accumulator: resolves a Booth sum/carry pair, aligns the product by a shift,
// and accumulates signed terms into a wide fixed-point register. Emits one result per first..last group.
module kulisch_product_accumulator #(
  parameter int DWIDTH    = 16,
  parameter int ACC_WIDTH = 80,
  parameter int SHIFT_W   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*DWIDTH-1:0]    in_sum,
  input  logic [2*DWIDTH-1:0]    in_carry,
  input  logic                   in_sign,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_dat,
  output logic                   out_ovf
);

  localparam int PW    = 2 * DWIDTH;
  localparam int EXT_W = PW + (1 << SHIFT_W);

  // Two operands of equal sign producing a result of the other sign.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    add_overflow = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic                 s1_valid_r;
  logic [PW-1:0]        s1_prod_r;
  logic                 s1_sign_r;
  logic [SHIFT_W-1:0]   s1_shift_r;
  logic                 s1_first_r;
  logic                 s1_last_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic                 acc_ovf_r;
  logic                 out_valid_r;
  logic [ACC_WIDTH-1:0] out_dat_r;
  logic                 out_ovf_r;

  logic [PW-1:0]        prod_s;
  logic [EXT_W-1:0]     ext_s;
  logic                 trunc_s;
  logic [ACC_WIDTH-1:0] mag_s;
  logic [ACC_WIDTH-1:0] term_s;
  logic [ACC_WIDTH-1:0] base_s;
  logic                 base_ovf_s;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 ovf_next_s;
  logic                 s1_go_s;
  logic                 in_ready_s;

  // Product resolve, alignment, accumulate and handshake decisions.
  always_comb begin
    prod_s  = in_sum + in_carry;
    ext_s   = {{(EXT_W-PW){1'b0}}, s1_prod_r} << s1_shift_r;
    // The sign bit position counts as lost magnitude, so truncation starts at ACC_WIDTH-1.
    trunc_s = |ext_s[EXT_W-1:ACC_WIDTH-1];
    mag_s   = ext_s[ACC_WIDTH-1:0];
    if (s1_sign_r) begin
      term_s = ~mag_s + {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      term_s = mag_s;
    end
    if (s1_first_r) begin
      base_s     = {ACC_WIDTH{1'b0}};
      base_ovf_s = 1'b0;
    end else begin
      base_s     = acc_r;
      base_ovf_s = acc_ovf_r;
    end
    sum_s      = base_s + term_s;
    ovf_next_s = base_ovf_s | trunc_s |
                 add_overflow(base_s[ACC_WIDTH-1], term_s[ACC_WIDTH-1], sum_s[ACC_WIDTH-1]);
    s1_go_s    = s1_valid_r && !(s1_last_r && out_valid_r && !out_ready);
    in_ready_s = !rst && (!s1_valid_r || s1_go_s);
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_dat   = out_dat_r;
  assign out_ovf   = out_ovf_r;

  // Stage 1 capture of the resolved product and beat attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_prod_r  <= {PW{1'b0}};
      s1_sign_r  <= 1'b0;
      s1_shift_r <= {SHIFT_W{1'b0}};
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
    end else if (in_ready_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_prod_r  <= prod_s;
        s1_sign_r  <= in_sign;
        s1_shift_r <= in_shift;
        s1_first_r <= in_first;
        s1_last_r  <= in_last;
      end
    end
  end

  // Accumulator update; cleared once a group's result has been handed to the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      acc_ovf_r <= 1'b0;
    end else if (s1_go_s) begin
      if (s1_last_r) begin
        acc_r     <= {ACC_WIDTH{1'b0}};
        acc_ovf_r <= 1'b0;
      end else begin
        acc_r     <= sum_s;
        acc_ovf_r <= ovf_next_s;
      end
    end
  end

  // Output register: a new last beat wins over consumption of the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_dat_r   <= {ACC_WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
    end else if (s1_go_s && s1_last_r) begin
      out_valid_r <= 1'b1;
      out_dat_r   <= sum_s;
      out_ovf_r   <= ovf_next_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kulisch_product_accumulator.sv
// Scoreboard bench for kulisch_product_accumulator: a reference model pushes expected group
// results when beats are driven; a negedge monitor pops and compares on each output handshake.
module tb_kulisch_product_accumulator;

  localparam int DW = 16;
  localparam int AW = 80;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_sum;
  logic [31:0]   in_carry;
  logic          in_sign;
  logic [SW-1:0] in_shift;
  logic          in_first;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_dat;
  logic          out_ovf;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int cyc   = 0;
  logic [AW:0]   exp_q[$];
  logic [AW-1:0] m_acc;
  logic          m_ovf;
  logic [AW-1:0] last_dat;
  logic          last_ovf;

  kulisch_product_accumulator #(.DWIDTH(DW), .ACC_WIDTH(AW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_sign(in_sign), .in_shift(in_shift),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every consumed result must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [AW:0] e;
    if (!rst && out_valid && out_ready) begin
      n_out = n_out + 1;
      total = total + 1;
      last_dat = out_dat;
      last_ovf = out_ovf;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_out got=%h ovf=%b", out_dat, out_ovf);
      end else begin
        e = exp_q.pop_front();
        if ({out_ovf, out_dat} !== e) begin
          bad = bad + 1;
          $display("FAIL scoreboard got ovf=%b dat=%h exp ovf=%b dat=%h",
                   out_ovf, out_dat, e[AW], e[AW-1:0]);
        end
      end
    end
  end

  // Reference model of one beat, with overflow via a sign-extended wider sum.
  task automatic model_beat(input logic [31:0] prod, input logic [SW-1:0] shift,
                            input logic sign, input logic first, input logic last);
    logic [127:0]  wide;
    logic          trunc;
    logic [AW-1:0] term;
    logic [AW-1:0] base;
    logic          bovf;
    logic [AW:0]   s81;
    logic          nov;
    wide  = {96'd0, prod} << shift;
    trunc = (wide >> (AW - 1)) != 128'd0;
    term  = wide[AW-1:0];
    if (sign) term = -term;
    base  = first ? {AW{1'b0}} : m_acc;
    bovf  = first ? 1'b0 : m_ovf;
    s81   = {base[AW-1], base} + {term[AW-1], term};
    nov   = bovf | trunc | (s81[AW] != s81[AW-1]);
    if (last) begin
      exp_q.push_back({nov, s81[AW-1:0]});
      m_acc = {AW{1'b0}};
      m_ovf = 1'b0;
    end else begin
      m_acc = s81[AW-1:0];
      m_ovf = nov;
    end
  endtask

  task automatic drive_beat(input logic [31:0] prod, input logic [SW-1:0] shift,
                            input logic sign, input logic first, input logic last);
    logic [31:0] c;
    c        = $urandom;
    in_carry = c;
    in_sum   = prod - c;
    in_shift = shift;
    in_sign  = sign;
    in_first = first;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic send_beat(input logic [31:0] prod, input logic [SW-1:0] shift,
                           input logic sign, input logic first, input logic last);
    bit done;
    model_beat(prod, shift, sign, first, last);
    drive_beat(prod, shift, sign, first, last);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL accept_timeout got=no_accept exp=accept");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total = total + 4;
    if (in_ready !== 1'b0) begin bad = bad + 1; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin bad = bad + 1; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_dat !== {AW{1'b0}}) begin bad = bad + 1; $display("FAIL rst_out_dat got=%h exp=0", out_dat); end
    if (out_ovf !== 1'b0) begin bad = bad + 1; $display("FAIL rst_out_ovf got=%b exp=0", out_ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    send_beat(32'h0000_0123, 6'd4, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    total = total + 1;
    if (out_valid !== 1'b0) begin bad = bad + 1; $display("FAIL single_early got=%b exp=0", out_valid); end
    @(negedge clk);
    total = total + 3;
    if (out_valid !== 1'b1) begin bad = bad + 1; $display("FAIL single_latency got=%b exp=1", out_valid); end
    if (out_dat !== 80'h1230) begin bad = bad + 1; $display("FAIL single_dat got=%h exp=1230", out_dat); end
    if (out_ovf !== 1'b0) begin bad = bad + 1; $display("FAIL single_ovf got=%b exp=0", out_ovf); end
    wait_drain();
  endtask

  task automatic test_carry_wrap();
    model_beat(32'h0000_0001, 6'd0, 1'b0, 1'b1, 1'b1);
    drive_beat(32'h0000_0001, 6'd0, 1'b0, 1'b1, 1'b1);
    in_sum   = 32'hFFFF_FFFF;
    in_carry = 32'h0000_0002;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    total = total + 1;
    if (last_dat !== 80'd1) begin bad = bad + 1; $display("FAIL carry_wrap got=%h exp=1", last_dat); end
  endtask

  task automatic test_signed_group();
    int n0;
    n0 = n_out;
    send_beat(32'd5, 6'd0, 1'b0, 1'b1, 1'b0);
    send_beat(32'd7, 6'd0, 1'b1, 1'b0, 1'b1);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    total = total + 2;
    if (last_dat !== 80'hFFFF_FFFF_FFFF_FFFF_FFFE) begin
      bad = bad + 1; $display("FAIL signed_dat got=%h exp=fffffffffffffffffffe", last_dat);
    end
    if (n_out - n0 != 1) begin bad = bad + 1; $display("FAIL signed_pulses got=%0d exp=1", n_out - n0); end
  endtask

  task automatic test_overflow();
    send_beat(32'hFFFF_FFFF, 6'd47, 1'b0, 1'b1, 1'b0);
    send_beat(32'hFFFF_FFFF, 6'd47, 1'b0, 1'b0, 1'b1);
    wait_drain();
    total = total + 1;
    if (last_ovf !== 1'b1) begin bad = bad + 1; $display("FAIL ovf_add got=%b exp=1", last_ovf); end
    send_beat(32'd9, 6'd1, 1'b0, 1'b1, 1'b1);
    wait_drain();
    total = total + 1;
    if (last_ovf !== 1'b0) begin bad = bad + 1; $display("FAIL ovf_cleared got=%b exp=0", last_ovf); end
    send_beat(32'hFFFF_0000, 6'd50, 1'b0, 1'b1, 1'b1);
    wait_drain();
    total = total + 1;
    if (last_ovf !== 1'b1) begin bad = bad + 1; $display("FAIL ovf_trunc got=%b exp=1", last_ovf); end
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = n_out;
    out_ready = 1'b0;
    send_beat(32'd3, 6'd0, 1'b0, 1'b1, 1'b1);
    send_beat(32'd9, 6'd0, 1'b0, 1'b1, 1'b1);
    model_beat(32'd6, 6'd0, 1'b0, 1'b1, 1'b1);
    drive_beat(32'd6, 6'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total = total + 3;
      if (in_ready !== 1'b0) begin bad = bad + 1; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      if (out_valid !== 1'b1) begin bad = bad + 1; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
      if (out_dat !== 80'd3) begin bad = bad + 1; $display("FAIL bp_hold got=%h exp=3", out_dat); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    total = total + 1;
    if (in_ready !== 1'b1) begin bad = bad + 1; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    total = total + 2;
    if (out_valid !== 1'b1) begin bad = bad + 1; $display("FAIL bp_next_valid got=%b exp=1", out_valid); end
    if (out_dat !== 80'd9) begin bad = bad + 1; $display("FAIL bp_next_dat got=%h exp=9", out_dat); end
    wait_drain();
    total = total + 1;
    if (n_out - n0 != 3) begin bad = bad + 1; $display("FAIL bp_count got=%0d exp=3", n_out - n0); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic f;
    logic l;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 30; i++) begin
      f = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      l = (i == 29) ? 1'b1 : ($urandom_range(0, 2) == 0);
      send_beat($urandom, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), f, l);
    end
    total = total + 1;
    if (cyc - c0 != 30) begin bad = bad + 1; $display("FAIL b2b_cycles got=%0d exp=30", cyc - c0); end
    wait_drain();
  endtask

  task automatic test_reset_mid_group();
    send_beat(32'd10, 6'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total = total + 4;
    if (out_valid !== 1'b0) begin bad = bad + 1; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    if (out_dat !== {AW{1'b0}}) begin bad = bad + 1; $display("FAIL mid_rst_dat got=%h exp=0", out_dat); end
    if (out_ovf !== 1'b0) begin bad = bad + 1; $display("FAIL mid_rst_ovf got=%b exp=0", out_ovf); end
    if (in_ready !== 1'b0) begin bad = bad + 1; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
    m_acc = {AW{1'b0}};
    m_ovf = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(32'd4, 6'd0, 1'b0, 1'b1, 1'b1);
    wait_drain();
    total = total + 1;
    if (last_dat !== 80'd4) begin bad = bad + 1; $display("FAIL mid_rst_new got=%h exp=4", last_dat); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = 32'd0; in_carry = 32'd0; in_sign = 1'b0;
    in_shift = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    m_acc = {AW{1'b0}}; m_ovf = 1'b0; last_dat = {AW{1'b0}}; last_ovf = 1'b0;
    test_reset();
    test_single();
    test_carry_wrap();
    test_signed_group();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
